// File: rtl/lieat_axi_arbiter_if.sv
// AXI4 master-side bus bundle (AW/W/B/AR/R) used by lieat_axi_arbiter.
interface lieat_axi_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            awvalid;
   logic            awready;
   logic [3:0]      awid;
   logic [AW-1:0]   awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;

   logic            wvalid;
   logic            wready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast;

   logic            bvalid;
   logic            bready;
   logic [3:0]      bid;
   logic [1:0]      bresp;

   logic            arvalid;
   logic            arready;
   logic [3:0]      arid;
   logic [AW-1:0]   araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;

   logic            rvalid;
   logic            rready;
   logic [3:0]      rid;
   logic [DW-1:0]   rdata;
   logic            rlast;

   modport master (
      output awvalid, awid, awaddr, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready,
      output arvalid, arid, araddr, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rid, rdata, rlast,
      output rready
   );

   modport slave (
      input  awvalid, awid, awaddr, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready,
      input  arvalid, arid, araddr, arlen, arsize, arburst,
      output arready,
      output rvalid, rid, rdata, rlast,
      input  rready
   );
endinterface

// File: rtl/lieat_axi_arbiter.sv
// Multi-requester read arbiter plus single write pass-through onto one AXI4 master port.
// One outstanding read and one outstanding write, each with its own FSM.
module lieat_axi_arbiter #(
   parameter int NRD      = 2,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int ARB_MODE = 0
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic [NRD-1:0]      rq_arvalid,
   output logic [NRD-1:0]      rq_arready,
   input  logic [NRD*AW-1:0]   rq_araddr,
   input  logic [NRD*8-1:0]    rq_arlen,
   input  logic [NRD*3-1:0]    rq_arsize,
   output logic [NRD-1:0]      rq_rvalid,
   input  logic [NRD-1:0]      rq_rready,
   output logic [DW-1:0]       rq_rdata,
   output logic                rq_rlast,
   input  logic                wr_awvalid,
   output logic                wr_awready,
   input  logic [AW-1:0]       wr_awaddr,
   input  logic [7:0]          wr_awlen,
   input  logic [2:0]          wr_awsize,
   input  logic                wr_wvalid,
   output logic                wr_wready,
   input  logic [DW-1:0]       wr_wdata,
   input  logic [DW/8-1:0]     wr_wstrb,
   output logic                wr_bvalid,
   input  logic                wr_bready,
   output logic [1:0]          wr_bresp,
   lieat_axi_arbiter_if.master io_master,
   output logic                err_o
);
   localparam int WW = (NRD > 1) ? $clog2(NRD) : 1;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

   rd_state_t     rd_state;
   wr_state_t     wr_state;
   logic [WW-1:0] winner, rr_ptr, pick, next_ptr, cand_w;
   logic          found;
   int unsigned   cand;
   logic [AW-1:0] ar_addr, aw_addr;
   logic [7:0]    ar_len, aw_len, rbeat, wbeat;
   logic [2:0]    ar_size, aw_size;
   logic [3:0]    arid_val;
   logic          rid_ok, rd_err, wr_err;

   // Round-robin scans from rr_ptr with wrap; fixed priority scans from index 0.
   always_comb begin
      pick   = '0;
      found  = 1'b0;
      cand   = 0;
      cand_w = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         if (ARB_MODE == 1) cand = k;
         else               cand = (32'(rr_ptr) + k) % NRD;
         cand_w = WW'(cand);
         if (!found && rq_arvalid[cand_w]) begin
            found = 1'b1;
            pick  = cand_w;
         end
      end
   end

   assign next_ptr = (winner == WW'(NRD - 1)) ? '0 : winner + 1'b1;
   assign arid_val = 4'(winner) + 4'd1;
   assign rid_ok   = (io_master.rid == arid_val);
   assign err_o    = rd_err | wr_err;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= R_IDLE;
         winner   <= '0;
         rr_ptr   <= '0;
         ar_addr  <= '0;
         ar_len   <= '0;
         ar_size  <= '0;
         rbeat    <= '0;
         rd_err   <= 1'b0;
      end else begin
         case (rd_state)
            R_IDLE: if (|rq_arvalid) begin
               winner   <= pick;
               ar_addr  <= rq_araddr[pick*AW +: AW];
               ar_len   <= rq_arlen[pick*8 +: 8];
               ar_size  <= rq_arsize[pick*3 +: 3];
               rd_state <= R_ADDR;
            end
            R_ADDR: if (io_master.arready) begin
               rbeat    <= '0;
               rd_state <= R_DATA;
            end
            R_DATA: if (io_master.rvalid && io_master.rready) begin
               // A beat carrying a foreign id is drained but never counted.
               if (!rid_ok) begin
                  rd_err <= 1'b1;
               end else begin
                  rbeat <= rbeat + 8'd1;
                  if (io_master.rlast) begin
                     if (rbeat != ar_len) rd_err <= 1'b1;
                     rr_ptr   <= next_ptr;
                     rd_state <= R_IDLE;
                  end
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   always_comb begin
      rq_arready        = '0;
      rq_rvalid         = '0;
      rq_rdata          = '0;
      rq_rlast          = 1'b0;
      io_master.arvalid = 1'b0;
      io_master.arid    = '0;
      io_master.araddr  = '0;
      io_master.arlen   = '0;
      io_master.arsize  = '0;
      io_master.arburst = '0;
      io_master.rready  = 1'b0;
      case (rd_state)
         R_ADDR: begin
            io_master.arvalid  = 1'b1;
            io_master.arid     = arid_val;
            io_master.araddr   = ar_addr;
            io_master.arlen    = ar_len;
            io_master.arsize   = ar_size;
            io_master.arburst  = 2'b01;
            rq_arready[winner] = io_master.arready;
         end
         R_DATA: begin
            io_master.rready  = rid_ok ? rq_rready[winner] : io_master.rvalid;
            rq_rvalid[winner] = io_master.rvalid & rid_ok;
            rq_rdata          = io_master.rdata;
            rq_rlast          = io_master.rlast;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_state <= W_IDLE;
         aw_addr  <= '0;
         aw_len   <= '0;
         aw_size  <= '0;
         wbeat    <= '0;
         wr_err   <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE: if (wr_awvalid) begin
               aw_addr  <= wr_awaddr;
               aw_len   <= wr_awlen;
               aw_size  <= wr_awsize;
               wr_state <= W_ADDR;
            end
            W_ADDR: if (io_master.awready) begin
               wbeat    <= '0;
               wr_state <= W_DATA;
            end
            W_DATA: if (io_master.wvalid && io_master.wready) begin
               wbeat <= wbeat + 8'd1;
               if (wbeat == aw_len) wr_state <= W_RESP;
            end
            W_RESP: if (io_master.bvalid && io_master.bready) begin
               if (io_master.bid != 4'h0) wr_err <= 1'b1;
               wr_state <= W_IDLE;
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_awready        = 1'b0;
      wr_wready         = 1'b0;
      wr_bvalid         = 1'b0;
      wr_bresp          = '0;
      io_master.awvalid = 1'b0;
      io_master.awid    = '0;
      io_master.awaddr  = '0;
      io_master.awlen   = '0;
      io_master.awsize  = '0;
      io_master.awburst = '0;
      io_master.wvalid  = 1'b0;
      io_master.wdata   = '0;
      io_master.wstrb   = '0;
      io_master.wlast   = 1'b0;
      io_master.bready  = 1'b0;
      case (wr_state)
         W_ADDR: begin
            io_master.awvalid = 1'b1;
            io_master.awaddr  = aw_addr;
            io_master.awlen   = aw_len;
            io_master.awsize  = aw_size;
            io_master.awburst = 2'b01;
            wr_awready        = io_master.awready;
         end
         W_DATA: begin
            io_master.wvalid = wr_wvalid;
            io_master.wdata  = wr_wdata;
            io_master.wstrb  = wr_wstrb;
            io_master.wlast  = (wbeat == aw_len);
            wr_wready        = io_master.wready;
         end
         W_RESP: begin
            wr_bvalid        = io_master.bvalid;
            wr_bresp         = io_master.bresp;
            io_master.bready = wr_bready;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_lieat_axi_arbiter.sv
// Directed bench: round-robin instance (reads, writes, reset) and fixed-priority instance.
module tb_lieat_axi_arbiter;
   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Round-robin instance signals
   logic [1:0]  rq_arvalid, rq_arready, rq_rvalid, rq_rready;
   logic [63:0] rq_araddr;
   logic [15:0] rq_arlen;
   logic [5:0]  rq_arsize;
   logic [31:0] rq_rdata;
   logic        rq_rlast;
   logic        wr_awvalid, wr_awready, wr_wvalid, wr_wready, wr_bvalid, wr_bready, err;
   logic [31:0] wr_awaddr, wr_wdata;
   logic [7:0]  wr_awlen;
   logic [2:0]  wr_awsize;
   logic [3:0]  wr_wstrb;
   logic [1:0]  wr_bresp;

   // Fixed-priority instance signals
   logic [1:0]  f_arvalid, f_arready, f_rvalid, f_rready;
   logic [63:0] f_araddr;
   logic [15:0] f_arlen;
   logic [5:0]  f_arsize;
   logic [31:0] f_rdata;
   logic        f_rlast, f_awready, f_wready, f_bvalid, f_err;
   logic [1:0]  f_bresp;

   lieat_axi_arbiter_if #(.AW(32), .DW(32)) io0 ();
   lieat_axi_arbiter_if #(.AW(32), .DW(32)) io1 ();

   lieat_axi_arbiter #(.NRD(2), .AW(32), .DW(32), .ARB_MODE(0)) dut_rr (
      .clock(clock), .rst_n(rst_n),
      .rq_arvalid(rq_arvalid), .rq_arready(rq_arready), .rq_araddr(rq_araddr),
      .rq_arlen(rq_arlen), .rq_arsize(rq_arsize), .rq_rvalid(rq_rvalid),
      .rq_rready(rq_rready), .rq_rdata(rq_rdata), .rq_rlast(rq_rlast),
      .wr_awvalid(wr_awvalid), .wr_awready(wr_awready), .wr_awaddr(wr_awaddr),
      .wr_awlen(wr_awlen), .wr_awsize(wr_awsize), .wr_wvalid(wr_wvalid),
      .wr_wready(wr_wready), .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb),
      .wr_bvalid(wr_bvalid), .wr_bready(wr_bready), .wr_bresp(wr_bresp),
      .io_master(io0), .err_o(err)
   );

   lieat_axi_arbiter #(.NRD(2), .AW(32), .DW(32), .ARB_MODE(1)) dut_fp (
      .clock(clock), .rst_n(rst_n),
      .rq_arvalid(f_arvalid), .rq_arready(f_arready), .rq_araddr(f_araddr),
      .rq_arlen(f_arlen), .rq_arsize(f_arsize), .rq_rvalid(f_rvalid),
      .rq_rready(f_rready), .rq_rdata(f_rdata), .rq_rlast(f_rlast),
      .wr_awvalid(1'b0), .wr_awready(f_awready), .wr_awaddr(32'h0),
      .wr_awlen(8'h0), .wr_awsize(3'h0), .wr_wvalid(1'b0),
      .wr_wready(f_wready), .wr_wdata(32'h0), .wr_wstrb(4'h0),
      .wr_bvalid(f_bvalid), .wr_bready(1'b0), .wr_bresp(f_bresp),
      .io_master(io1), .err_o(f_err)
   );

   function automatic logic [31:0] req_addr(input int w);
      return (w == 0) ? 32'h0000_1000 : 32'h0000_2000;
   endfunction

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   // nstop < nb leaves the burst unfinished; drop clears arvalid while in R_ADDR.
   task automatic rd_burst(input int w, input int nb, input int nstop, input bit inject, input bit drop);
      int t = 0;
      while (io0.arvalid !== 1'b1 && t < 20) begin tick(); t++; end
      if (t == 20) begin check("ar_wait_timeout", 0, 1); return; end
      check("arid", io0.arid, w + 1);
      check("araddr", io0.araddr, req_addr(w));
      check("arlen", io0.arlen, nb - 1);
      check("arburst", io0.arburst, 2'b01);
      if (drop) rq_arvalid[w] = 1'b0;
      io0.arready = 1'b1;
      #1 check("rq_arready", rq_arready, 2'b01 << w);
      tick();
      io0.arready = 1'b0;
      for (int b = 0; b < nstop; b++) begin
         if (inject && b == 1) begin
            io0.rvalid = 1'b1; io0.rid = (w == 1) ? 4'd1 : 4'd2;
            io0.rdata = 32'hBAD0_BAD0; io0.rlast = 1'b0;
            #1;
            check("inj_rready", io0.rready, 1);
            check("inj_rvalid", rq_rvalid, 0);
            tick();
         end
         io0.rvalid = 1'b1; io0.rid = 4'(w + 1);
         io0.rdata = 32'hD000_0000 + 32'(w * 16 + b);
         io0.rlast = (b == nb - 1);
         #1;
         check("rq_rvalid", rq_rvalid, 2'b01 << w);
         check("rq_rdata", rq_rdata, 32'hD000_0000 + 32'(w * 16 + b));
         check("rq_rlast", rq_rlast, (b == nb - 1));
         check("io_rready", io0.rready, 1);
         tick();
      end
      io0.rvalid = 1'b0; io0.rlast = 1'b0;
   endtask

   task automatic wr_burst(input int nb, input logic [1:0] resp);
      int t = 0;
      while (io0.awvalid !== 1'b1 && t < 20) begin tick(); t++; end
      if (t == 20) begin check("aw_wait_timeout", 0, 1); return; end
      check("awaddr", io0.awaddr, 32'h0000_3000);
      check("awlen", io0.awlen, nb - 1);
      check("awid", io0.awid, 0);
      check("awburst", io0.awburst, 2'b01);
      io0.awready = 1'b1;
      #1 check("wr_awready", wr_awready, 1);
      tick();
      io0.awready = 1'b0; wr_awvalid = 1'b0;
      for (int b = 0; b < nb; b++) begin
         wr_wvalid = 1'b1; wr_wdata = 32'hA000_0000 + 32'(b); wr_wstrb = 4'hF;
         io0.wready = 1'b1;
         #1;
         check("wvalid", io0.wvalid, 1);
         check("wlast", io0.wlast, (b == nb - 1));
         check("wdata", io0.wdata, 32'hA000_0000 + 32'(b));
         check("wstrb", io0.wstrb, 4'hF);
         check("wr_wready", wr_wready, 1);
         tick();
      end
      wr_wvalid = 1'b0; io0.wready = 1'b0;
      io0.bvalid = 1'b1; io0.bid = 4'h0; io0.bresp = resp; wr_bready = 1'b1;
      #1;
      check("wr_bvalid", wr_bvalid, 1);
      check("wr_bresp", wr_bresp, resp);
      check("bready", io0.bready, 1);
      tick();
      io0.bvalid = 1'b0; wr_bready = 1'b0; io0.bresp = 2'b00;
      #1;
      check("w_idle_bready", io0.bready, 0);
      check("w_idle_awvalid", io0.awvalid, 0);
   endtask

   task automatic fp_read(input int w);
      int t = 0;
      while (io1.arvalid !== 1'b1 && t < 20) begin tick(); t++; end
      if (t == 20) begin check("fp_ar_timeout", 0, 1); return; end
      check("fp_arid", io1.arid, w + 1);
      io1.arready = 1'b1;
      #1 check("fp_arready", f_arready, 2'b01 << w);
      tick();
      io1.arready = 1'b0;
      io1.rvalid = 1'b1; io1.rid = 4'(w + 1); io1.rlast = 1'b1; io1.rdata = 32'hF0F0_0000 + 32'(w);
      #1 check("fp_rvalid", f_rvalid, 2'b01 << w);
      tick();
      io1.rvalid = 1'b0; io1.rlast = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rq_arvalid = '0; rq_rready = 2'b11; rq_araddr = {32'h0000_2000, 32'h0000_1000};
      rq_arlen = '0; rq_arsize = {3'd2, 3'd2};
      wr_awvalid = 1'b0; wr_awaddr = 32'h0000_3000; wr_awlen = 8'd2; wr_awsize = 3'd2;
      wr_wvalid = 1'b0; wr_wdata = '0; wr_wstrb = '0; wr_bready = 1'b0;
      f_arvalid = '0; f_rready = 2'b11; f_araddr = {32'h0000_2000, 32'h0000_1000};
      f_arlen = '0; f_arsize = '0;
      io0.awready = 0; io0.wready = 0; io0.bvalid = 0; io0.bid = 0; io0.bresp = 0;
      io0.arready = 0; io0.rvalid = 0; io0.rid = 0; io0.rdata = 0; io0.rlast = 0;
      io1.awready = 0; io1.wready = 0; io1.bvalid = 0; io1.bid = 0; io1.bresp = 0;
      io1.arready = 0; io1.rvalid = 0; io1.rid = 0; io1.rdata = 0; io1.rlast = 0;

      tick();
      rq_arvalid = 2'b11; wr_awvalid = 1'b1;
      #1;
      check("rst_rq_arready", rq_arready, 0);
      check("rst_arvalid", io0.arvalid, 0);
      check("rst_awvalid", io0.awvalid, 0);
      check("rst_wr_awready", wr_awready, 0);
      check("rst_err", err, 0);
      tick();
      rq_arvalid = '0; wr_awvalid = 1'b0;
      rst_n = 1'b1;

      // Fixed priority: 0 always wins while it requests
      f_arvalid = 2'b11;
      fp_read(0);
      fp_read(0);
      fp_read(0);
      f_arvalid = 2'b10;
      fp_read(1);
      f_arvalid = 2'b00;

      // Round-robin alternation with len=0
      rq_arvalid = 2'b11;
      rd_burst(0, 1, 1, 0, 0);
      rd_burst(1, 1, 1, 0, 0);
      rd_burst(0, 1, 1, 0, 0);
      rd_burst(1, 1, 1, 0, 0);
      rq_arvalid = 2'b10; rq_arlen = {8'd3, 8'd0};
      rd_burst(1, 4, 4, 0, 0);
      check("err_clean_burst", err, 0);
      rd_burst(1, 4, 4, 1, 1);
      check("err_foreign_rid", err, 1);

      wr_awvalid = 1'b1;
      wr_burst(3, 2'b00);
      check("err_sticky", err, 1);

      rst_n = 1'b0;
      #1 check("err_after_rst", err, 0);
      tick();
      rst_n = 1'b1;

      // Concurrent read and write
      rq_arvalid = 2'b10; wr_awvalid = 1'b1;
      fork
         rd_burst(1, 4, 4, 0, 1);
         wr_burst(3, 2'b10);
      join
      check("err_concurrent", err, 0);

      // Advance rr_ptr to 1, then reset mid-burst
      rq_arlen = {8'd3, 8'd0}; rq_arvalid = 2'b01;
      rd_burst(0, 1, 1, 0, 1);
      rq_arlen = {8'd3, 8'd3}; rq_arvalid = 2'b01;
      rd_burst(0, 4, 2, 0, 1);
      io0.rvalid = 1'b1; io0.rid = 4'd1; io0.rdata = 32'h5555_AAAA; io0.rlast = 1'b0;
      #1 check("beat2_rvalid", rq_rvalid, 2'b01);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rvalid", rq_rvalid, 0);
      check("mid_rst_rdata", rq_rdata, 0);
      check("mid_rst_rready", io0.rready, 0);
      check("mid_rst_arready", rq_arready, 0);
      tick();
      io0.rvalid = 1'b0;
      rst_n = 1'b1;
      tick();
      check("post_rst_rvalid", rq_rvalid, 0);
      check("post_rst_arvalid", io0.arvalid, 0);
      rq_arlen = '0; rq_arvalid = 2'b11;
      rd_burst(0, 1, 1, 0, 0);
      rq_arvalid = '0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lieat_axi_arbiter.md
LIEAT_AXI_ARBITER -- requirements
Module: lieat_axi_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NRD, 2, number of read requesters; index 0 is highest fixed priority.
- AW, 32, address width.
- DW, 32, data width.
- ARB_MODE, 0, read arbitration: 0 = round-robin, 1 = fixed priority.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, sole clock.
- rst_n, in, 1, reset.
- rq_arvalid/rq_arready, in/out, NRD, per-requester AR handshake.
- rq_araddr, in, NRD*AW, packed addresses; requester i at [i*AW +: AW].
- rq_arlen, in, NRD*8, packed burst lengths (beats-1).
- rq_arsize, in, NRD*3, packed sizes.
- rq_rvalid/rq_rready, out/in, NRD, per-requester R handshake.
- rq_rdata, out, DW, shared read data, valid only where rq_rvalid is set.
- rq_rlast, out, 1, last beat.
- wr_awvalid/wr_awready, in/out, 1, write-requester AW handshake.
- wr_awaddr, in, AW, write address.
- wr_awlen, in, 8, write burst length (beats-1).
- wr_awsize, in, 3, write size.
- wr_wvalid/wr_wready, in/out, 1, write-requester W handshake.
- wr_wdata, in, DW, write data.
- wr_wstrb, in, DW/8, write byte strobes.
- wr_bvalid/wr_bready, out/in, 1, write-response handshake.
- wr_bresp, out, 2, write response.
- io_master_*, AXI4 master AW/W/B/AR/R port set, widths AW/DW, id 4 bits, len 8, size 3, burst 2.
- err_o, out, 1, sticky protocol-error flag.
REQ-003 There SHALL be one clock, clock; rst_n SHALL be asynchronous and active-low.

Function
REQ-004 The read path SHALL be a state machine with states R_IDLE, R_ADDR and R_DATA, and SHALL allow one outstanding read.
REQ-005 In R_IDLE with any rq_arvalid set, the block SHALL select a winner and latch its addr, len and size; the state SHALL then be R_ADDR.
- ARB_MODE 0 (round-robin): the winner SHALL be the first requester at or after rr_ptr, with wrap-around.
- ARB_MODE 1 (fixed priority): the winner SHALL be the lowest set index.
REQ-006 In R_ADDR the AR outputs SHALL be driven from the latched registers as follows:
- io_master_arvalid=1, arid=winner+1, arburst=2'b01 (INCR).
- On io_master_arready, rq_arready[winner] SHALL pulse that same cycle and the state SHALL move to R_DATA.
- Latency SHALL be 1 cycle from the arbitration cycle to io_master_arvalid.
REQ-007 In R_DATA the R channel SHALL be routed as follows:
- io_master_rready SHALL equal rq_rready[winner].
- rq_rvalid[winner] SHALL equal io_master_rvalid & (rid==winner+1).
- rq_rdata and rq_rlast SHALL pass through combinationally.
REQ-008 An 8-bit beat counter SHALL increment on each accepted R beat.
- On an accepted beat with rlast, the state SHALL return to R_IDLE.
- rr_ptr SHALL become (winner+1) mod NRD.
REQ-009 err_o SHALL set when either of the following occurs in R_DATA:
- An R beat has rid≠winner+1; that beat SHALL be consumed (io_master_rready=1) and not forwarded.
- rlast arrives with beat count ≠ latched len.
REQ-010 Requesters not granted SHALL see rq_arready=0 and rq_rvalid=0 at all times.
REQ-011 A requester dropping arvalid while in R_ADDR SHALL NOT cancel the latched request.
REQ-012 The write path SHALL be a state machine with states W_IDLE, W_ADDR, W_DATA and W_RESP, independent of the read path.
- W_IDLE→W_ADDR on wr_awvalid, latching addr, len and size.
- W_ADDR: io_master_awvalid=1, awid=4'h0, awburst=INCR; wr_awready SHALL pulse on io_master_awready; then W_DATA.
REQ-013 In W_DATA the W channel SHALL be routed as follows:
- io_master_wvalid=wr_wvalid and wr_wready=io_master_wready.
- wdata and wstrb SHALL pass through.
- io_master_wlast SHALL be 1 exactly when the beat counter equals the latched len.
- The last accepted beat SHALL move the state to W_RESP.
REQ-014 In W_RESP the B channel SHALL be routed as follows:
- wr_bvalid=io_master_bvalid, io_master_bready=wr_bready, wr_bresp=io_master_bresp.
- On the B handshake the state SHALL return to W_IDLE.
- A bid≠0 SHALL set err_o.
REQ-015 Outside their active states, all io_master valid/ready outputs and all rq/wr ready/valid outputs SHALL be 0.

Reset
REQ-016 rst_n low SHALL, asynchronously, set both state machines to their idle states.
REQ-017 rst_n low SHALL, asynchronously, clear the counters, rr_ptr, err_o and all latched registers to 0.
REQ-018 All outputs SHALL read 0 during reset.
REQ-019 Reset asserted mid-burst SHALL abandon the transaction, with no completion pulse afterward.

Verification
REQ-020 ARB_MODE 0, NRD=2, both requesters continuously requesting len=0:
- Required response: AR grants alternate 0,1,0,1.
- Required response: arid alternates 1,2.
REQ-021 ARB_MODE 1, both requesters requesting:
- Required response: requester 0 wins every arbitration.
- Required response: requester 1 is granted only when rq_arvalid[0]=0.
REQ-022 Read with arlen=3 from requester 1:
- Required response: 4 beats delivered to requester 1 only, rlast on beat 4.
- Required response: err_o stays 0.
- Injection: an extra rid=1 beat during the burst → beat is consumed and err_o=1.
REQ-023 Write with awlen=2, wstrb=0xF:
- Required response: wlast high on the third beat only.
- Required response: bresp=2'b00 forwarded, then the write path returns to idle.
REQ-024 Concurrent read and write:
- Required response: both complete independently.
- Reset asserted during read beat 2 → all outputs 0 immediately, and the next request arbitrates from rr_ptr=0.
